// File: rtl/mips32r2_utlb_walker_pkg.sv
// Shared TLB types, kseg decode constants and the page-size mask used by the
// micro-TLB and the slow-TLB probe, plus the entry-to-physical translation.
package mips32r2_utlb_walker_pkg;

  typedef enum logic [1:0] {
    PS4K  = 2'd0,
    PS16K = 2'd1,
    PS64K = 2'd2
  } page_size_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'd0,
    EXC_REFILL   = 2'd1,
    EXC_INVALID  = 2'd2,
    EXC_MODIFIED = 2'd3
  } tlb_exc_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    page_size_e  ps;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    tlb_exc_e    exc;
  } xlate_t;

  localparam logic [1:0]  KSEG01_TOP   = 2'b10;
  localparam logic [31:0] KSEG_PMASK   = 32'h1FFF_FFFF;
  localparam logic [2:0]  CCA_UNCACHED = 3'd2;

  // Larger pages ignore the low VPN2 bits that fall inside the page pair.
  function automatic logic [18:0] vpn2_mask(input page_size_e ps);
    case (ps)
      PS16K:   return 19'h7FFFC;
      PS64K:   return 19'h7FFF0;
      default: return 19'h7FFFF;
    endcase
  endfunction

  function automatic xlate_t translate(input tlb_entry_t e, input logic [31:0] vaddr,
                                       input logic store);
    xlate_t      r;
    logic        odd;
    logic [31:0] off_mask;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
    case (e.ps)
      PS16K:   begin odd = vaddr[14]; off_mask = 32'h0000_3FFF; end
      PS64K:   begin odd = vaddr[16]; off_mask = 32'h0000_FFFF; end
      default: begin odd = vaddr[12]; off_mask = 32'h0000_0FFF; end
    endcase
    pfn = odd ? e.pfn1 : e.pfn0;
    c   = odd ? e.c1   : e.c0;
    d   = odd ? e.d1   : e.d0;
    v   = odd ? e.v1   : e.v0;
    r.paddr    = {pfn, 12'b0} | (vaddr & off_mask);
    r.uncached = (c == CCA_UNCACHED);
    r.exc      = EXC_NONE;
    if (!v)              r.exc = EXC_INVALID;
    else if (store && !d) r.exc = EXC_MODIFIED;
    if (r.exc != EXC_NONE) begin
      r.paddr    = '0;
      r.uncached = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mips32r2_utlb_array.sv
// Fully-associative micro-TLB: parallel match, round-robin replacement and
// a flush that wins over a same-cycle install.
module mips32r2_utlb_array
  import mips32r2_utlb_walker_pkg::*;
#(
  parameter int UTLB_ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [18:0] lookup_vpn2,
  input  logic [7:0]  lookup_asid,
  output logic        hit,
  output tlb_entry_t  hit_entry,
  input  logic        install,
  input  tlb_entry_t  install_entry
);

  localparam int PW = $clog2(UTLB_ENTRIES);

  tlb_entry_t              ent [UTLB_ENTRIES];
  logic [UTLB_ENTRIES-1:0] valid;
  logic [UTLB_ENTRIES-1:0] match;
  logic [PW-1:0]           ptr;

  // Lowest matching index wins; a flush in the same cycle hides every entry.
  always_comb begin
    match     = '0;
    hit_entry = '0;
    for (int i = UTLB_ENTRIES - 1; i >= 0; i--) begin
      match[i] = valid[i]
              && ((ent[i].vpn2 & vpn2_mask(ent[i].ps)) == (lookup_vpn2 & vpn2_mask(ent[i].ps)))
              && (ent[i].g || (ent[i].asid == lookup_asid));
      if (match[i]) hit_entry = ent[i];
    end
  end

  assign hit = (|match) && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      ptr   <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (install) begin
      valid[ptr] <= 1'b1;
      ptr        <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (install && !flush) ent[ptr] <= install_entry;
  end

endmodule

// File: rtl/mips32r2_utlb_walker.sv
// Translation front end: micro-TLB lookup, slow-TLB probe walk on a miss,
// and a registered one-cycle response with the TLB exception code.
module mips32r2_utlb_walker
  import mips32r2_utlb_walker_pkg::*;
#(
  parameter int ENTRIES      = 64,
  parameter int GROUP_SIZE   = 4,
  parameter int UTLB_ENTRIES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_vaddr,
  input  logic [7:0]  req_asid,
  input  logic        req_store,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_uncached,
  output logic [1:0]  resp_exc,
  input  logic        flush,
  input  logic        tlb_w_valid,
  output logic [18:0] p_ivpn2,
  output logic [7:0]  p_iasid,
  input  logic        p_ready,
  input  tlb_entry_t  p_resp,
  output logic [1:0]  dbg_state
);

  localparam int GROUPS = ENTRIES / GROUP_SIZE;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GROUPS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_PROBE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    state;
  logic [31:0]   vaddr_q;
  logic [7:0]    asid_q;
  logic          store_q;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          install;
  logic          go_resp;
  tlb_entry_t    hit_entry;
  xlate_t        hit_x;
  xlate_t        probe_x;
  xlate_t        resp_d;

  // Handshake: a request is taken on any edge where req_valid && req_ready;
  // req_ready is high only in IDLE. resp_valid is a single-cycle pulse with
  // no back-pressure, so the consumer must take it when it appears.
  assign req_ready = (state == S_IDLE);
  assign dbg_state = state;
  assign install   = (state == S_PROBE) && p_ready && !tlb_w_valid && !flush;
  assign hit_x     = translate(hit_entry, vaddr_q, store_q);
  assign probe_x   = translate(p_resp, vaddr_q, store_q);

  mips32r2_utlb_array #(.UTLB_ENTRIES(UTLB_ENTRIES)) u_array (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .lookup_vpn2   (vaddr_q[31:13]),
    .lookup_asid   (asid_q),
    .hit           (hit),
    .hit_entry     (hit_entry),
    .install       (install),
    .install_entry (p_resp)
  );

  always_comb begin
    resp_d  = '0;
    go_resp = 1'b0;
    if (state == S_LOOKUP) begin
      if (vaddr_q[31:30] == KSEG01_TOP) begin
        resp_d.paddr    = vaddr_q & KSEG_PMASK;
        resp_d.uncached = vaddr_q[29];
        resp_d.exc      = EXC_NONE;
        go_resp         = 1'b1;
      end else if (hit) begin
        resp_d  = hit_x;
        go_resp = 1'b1;
      end
    end else if (state == S_PROBE) begin
      if (install) begin
        resp_d  = probe_x;
        go_resp = 1'b1;
      end else if (!(tlb_w_valid || flush) && (cnt == CNT_LAST)) begin
        // A full rotation passed without a match.
        resp_d.exc = EXC_REFILL;
        go_resp    = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      vaddr_q       <= '0;
      asid_q        <= '0;
      store_q       <= 1'b0;
      cnt           <= '0;
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_uncached <= 1'b0;
      resp_exc      <= EXC_NONE;
      p_ivpn2       <= '0;
      p_iasid       <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (go_resp) begin
        resp_valid    <= 1'b1;
        resp_paddr    <= resp_d.paddr;
        resp_uncached <= resp_d.uncached;
        resp_exc      <= resp_d.exc;
        state         <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              vaddr_q <= req_vaddr;
              asid_q  <= req_asid;
              store_q <= req_store;
              state   <= S_LOOKUP;
            end
          end
          S_LOOKUP: begin
            cnt     <= '0;
            p_ivpn2 <= vaddr_q[31:13];
            p_iasid <= asid_q;
            state   <= S_PROBE;
          end
          S_PROBE: begin
            // A pending slow-TLB write invalidates the rotation seen so far.
            if (tlb_w_valid || flush) cnt <= '0;
            else                      cnt <= cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mips32r2_utlb_walker.sv
// Bench for the micro-TLB walker: directed scenarios then random requests,
// each response compared with an arithmetic model of the TLBs.
module tb_mips32r2_utlb_walker;
  import mips32r2_utlb_walker_pkg::*;

  localparam int GROUPS = 16;
  localparam int UN     = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready, req_store;
  logic [31:0] req_vaddr;
  logic [7:0]  req_asid;
  logic        resp_valid, resp_uncached;
  logic [31:0] resp_paddr;
  logic [1:0]  resp_exc;
  logic        flush, tlb_w_valid, p_ready;
  logic [18:0] p_ivpn2;
  logic [7:0]  p_iasid;
  tlb_entry_t  p_resp;
  logic [1:0]  dbg_state;

  mips32r2_utlb_walker #(.ENTRIES(64), .GROUP_SIZE(4), .UTLB_ENTRIES(UN)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
    .req_asid(req_asid), .req_store(req_store),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr),
    .resp_uncached(resp_uncached), .resp_exc(resp_exc),
    .flush(flush), .tlb_w_valid(tlb_w_valid),
    .p_ivpn2(p_ivpn2), .p_iasid(p_iasid), .p_ready(p_ready), .p_resp(p_resp),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  tlb_entry_t  slow_tlb[$];
  tlb_entry_t  u_ent[UN];
  bit          u_val[UN];
  int          u_ptr = 0;
  logic [18:0] last_vpn2 = '0;
  logic [7:0]  last_asid = '0;
  tlb_entry_t  no_entry = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic tlb_entry_t mk(logic [18:0] vpn2, logic [7:0] asid, logic g, int ps,
                                    logic [19:0] pfn0, logic [2:0] c0, logic d0, logic v0,
                                    logic [19:0] pfn1, logic [2:0] c1, logic d1, logic v1);
    tlb_entry_t e;
    e.vpn2 = vpn2; e.asid = asid; e.g = g; e.ps = page_size_e'(2'(ps));
    e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
    e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
    return e;
  endfunction

  // A page pair covers 8K << (2*ps) bytes starting at the masked VPN2.
  function automatic bit ent_match(tlb_entry_t e, logic [31:0] va, logic [7:0] asid);
    int          sh;
    logic [31:0] vpage, epage;
    sh    = 2 * int'(e.ps);
    vpage = va >> (13 + sh);
    epage = {13'b0, e.vpn2} >> sh;
    return (vpage == epage) && (e.g || (e.asid == asid));
  endfunction

  function automatic void model_xlate(input tlb_entry_t e, input logic [31:0] va, input logic st,
                                      output logic [31:0] pa, output logic unc,
                                      output logic [1:0] exc);
    longint unsigned psz, v, off, pf;
    bit              odd;
    logic [2:0]      c;
    logic            d, vb;
    psz = 64'd4096 << (2 * int'(e.ps));
    v   = {32'b0, va};
    odd = ((v / psz) % 2) == 1;
    off = v % psz;
    pf  = odd ? {44'b0, e.pfn1} : {44'b0, e.pfn0};
    c   = odd ? e.c1 : e.c0;
    d   = odd ? e.d1 : e.d0;
    vb  = odd ? e.v1 : e.v0;
    pa  = 32'((pf * 4096) | off);
    unc = (c == 3'd2);
    exc = 2'd0;
    if (!vb)           exc = 2'd2;
    else if (st && !d) exc = 2'd3;
    if (exc != 2'd0) begin pa = '0; unc = 1'b0; end
  endfunction

  function automatic int u_find(logic [31:0] va, logic [7:0] asid);
    for (int i = 0; i < UN; i++) if (u_val[i] && ent_match(u_ent[i], va, asid)) return i;
    return -1;
  endfunction

  function automatic int slow_find(logic [31:0] va, logic [7:0] asid);
    foreach (slow_tlb[i]) if (ent_match(slow_tlb[i], va, asid)) return i;
    return -1;
  endfunction

  function automatic void u_clear();
    for (int i = 0; i < UN; i++) u_val[i] = 1'b0;
  endfunction

  // One request end to end. delay: probe cycle that sees p_ready for a slow-TLB
  // hit; rs: probe cycle with tlb_w_valid (and an ignored p_ready); fl: flush
  // in the lookup cycle.
  task automatic do_req(input logic [31:0] va, input logic [7:0] asid, input logic st,
                        input int delay, input int rs, input bit fl, input string tag);
    logic [31:0]     e_pa;
    logic            e_unc;
    logic [1:0]      e_exc;
    int              ui, si, lat, c, rc;
    bit              probing, got;
    longint unsigned v;
    probing = 0; si = -1; e_pa = '0; e_unc = 1'b0; e_exc = 2'd0;
    if (fl) u_clear();
    if (va[31:30] == 2'b10) begin
      v = {32'b0, va};
      e_pa = 32'(v % 64'd536870912); e_unc = va[29]; lat = 2;
    end else begin
      ui = u_find(va, asid);
      if (ui >= 0) begin
        model_xlate(u_ent[ui], va, st, e_pa, e_unc, e_exc); lat = 2;
      end else begin
        probing = 1;
        si = slow_find(va, asid);
        if (si >= 0) begin
          model_xlate(slow_tlb[si], va, st, e_pa, e_unc, e_exc); lat = delay + 3;
        end else begin
          e_exc = 2'd1; lat = (rs >= 0) ? rs + 19 : GROUPS + 2;
        end
      end
    end
    @(negedge clock);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_vaddr = va; req_asid = asid; req_store = st;
    got = 0; c = 0; rc = -1;
    while (!got && c < 64) begin
      @(negedge clock);
      c++;
      req_valid = 1'b0; p_ready = 1'b0; tlb_w_valid = 1'b0; p_resp = '0;
      flush = fl && (c == 1);
      if (resp_valid) begin
        got = 1; rc = c;
      end else if (probing && c >= 2) begin
        if (c == 2) begin
          chk({tag, "_pvpn2"}, 32'(p_ivpn2), 32'(va[31:13]));
          chk({tag, "_pasid"}, 32'(p_iasid), 32'(asid));
        end
        if (c - 2 == rs) begin
          tlb_w_valid = 1'b1; p_ready = 1'b1; p_resp = slow_tlb[0];
        end else if (si >= 0 && c - 2 == delay) begin
          p_ready = 1'b1; p_resp = slow_tlb[si];
        end
      end
    end
    flush = 1'b0;
    chk({tag, "_got"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(rc), 32'(lat));
    chk({tag, "_paddr"}, resp_paddr, e_pa);
    chk({tag, "_unc"}, 32'(resp_uncached), 32'(e_unc));
    chk({tag, "_exc"}, 32'(resp_exc), 32'(e_exc));
    if (!probing) chk({tag, "_pvpn2_hold"}, 32'(p_ivpn2), 32'(last_vpn2));
    @(negedge clock);
    chk({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    if (probing) begin
      last_vpn2 = va[31:13]; last_asid = asid;
      if (si >= 0) begin
        u_ent[u_ptr] = slow_tlb[si]; u_val[u_ptr] = 1'b1; u_ptr = (u_ptr + 1) % UN;
      end
    end
  endtask

  task automatic do_flush();
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    u_clear();
  endtask

  // Address somewhere inside entry i's page pair; wrong_asid picks a non-matching ASID.
  task automatic req_entry(input int i, input logic st, input int delay, input bit wrong_asid,
                           input bit fl, input string tag);
    tlb_entry_t  e;
    int          sh;
    logic [31:0] span, base, va;
    logic [7:0]  asid;
    e    = slow_tlb[i];
    sh   = 2 * int'(e.ps);
    span = 32'd8192 << sh;
    base = ({13'b0, e.vpn2} >> sh) << (13 + sh);
    va   = base + ($urandom % span);
    asid = e.g ? 8'($urandom) : (wrong_asid ? (e.asid ^ 8'h80) : e.asid);
    do_req(va, asid, st, delay, -1, fl, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, rv_seen;
    req_valid = 1'b0; req_vaddr = '0; req_asid = '0; req_store = 1'b0;
    flush = 1'b0; tlb_w_valid = 1'b0; p_ready = 1'b0; p_resp = '0;
    u_clear();
    // Slow TLB contents: two directed entries, eight random ones in a separate region.
    slow_tlb.push_back(mk(19'h00401, 8'd5, 1'b0, 0, 20'h12345, 3'd3, 1'b1, 1'b1,
                          20'h02468, 3'd2, 1'b0, 1'b1));
    slow_tlb.push_back(mk(19'h00802, 8'd5, 1'b0, 0, 20'h0ABCD, 3'd3, 1'b0, 1'b1,
                          20'h0BEEF, 3'd3, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++)
      slow_tlb.push_back(mk(19'h10000 + 19'(i << 6), 8'h10 + 8'(i), (i == 3 || i == 6), i % 3,
                            20'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                            ($urandom_range(0, 3) != 0),
                            20'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                            ($urandom_range(0, 3) != 0)));

    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_paddr", resp_paddr, 32'd0);
    chk("rst_unc", 32'(resp_uncached), 32'd0);
    chk("rst_exc", 32'(resp_exc), 32'd0);
    chk("rst_pvpn2", 32'(p_ivpn2), 32'd0);
    chk("rst_pasid", 32'(p_iasid), 32'd0);

    do_req(32'hA000_1234, 8'd0, 1'b0, 0, -1, 0, "kseg1");
    do_req(32'h8012_3456, 8'd3, 1'b1, 0, -1, 0, "kseg0");
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 7, -1, 0, "miss_a");
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 0, -1, 0, "hit_a");
    do_req(32'h0080_3ABC, 8'd5, 1'b1, 0, -1, 0, "hit_a_odd_store");
    do_req(32'h0080_3ABC, 8'd5, 1'b0, 0, -1, 0, "hit_a_odd_load");
    do_req(32'h0100_4010, 8'd5, 1'b1, 0, -1, 0, "store_clean");
    do_req(32'h0100_4010, 8'd5, 1'b0, 0, -1, 0, "load_clean");
    do_req(32'h0100_5010, 8'd5, 1'b0, 0, -1, 0, "load_invalid");
    do_req(32'h0080_2ABC, 8'd6, 1'b0, 0, -1, 0, "asid_mismatch");
    do_req(32'h4000_0000, 8'd5, 1'b0, 0, -1, 0, "timeout");
    do_req(32'h0080_2000, 8'd5, 1'b0, 0, -1, 0, "after_timeout_hit");
    do_req(32'h4000_2000, 8'd5, 1'b0, 0, 10, 0, "restart");
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 3, -1, 1, "flush_in_lookup");
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 15, -1, 0, "hit_last_probe");

    do_flush();
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 2, -1, 0, "after_flush_a");
    do_flush();
    for (int i = 2; i < 7; i++) req_entry(i, 1'b0, 4, 0, 0, "fill");
    req_entry(2, 1'b0, 4, 0, 0, "evicted_first");
    req_entry(6, 1'b0, 4, 0, 0, "kept_last");

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 11);
      if (k == 0)      do_req({2'b10, 30'($urandom)}, 8'($urandom), 1'($urandom), 0, -1, 0, "rnd_kseg");
      else if (k == 1) do_req(32'h4000_0000 | ($urandom & 32'h0FFF_FFFF), 8'($urandom),
                              1'($urandom), 0, -1, 0, "rnd_refill");
      else if (k == 2) req_entry($urandom_range(2, 9), 1'($urandom), $urandom_range(0, 15), 1, 0, "rnd_asid");
      else if (k == 3) do_flush();
      else req_entry($urandom_range(2, 9), 1'($urandom), $urandom_range(0, 15), 0,
                     ($urandom_range(0, 7) == 0), "rnd_entry");
    end

    // Reset while probing: the request is dropped without a response.
    @(negedge clock);
    req_valid = 1'b1; req_vaddr = 32'h4000_4000; req_asid = 8'd1; req_store = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("rst_probe_resp_valid", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    u_clear(); u_ptr = 0; last_vpn2 = '0; last_asid = '0;
    rv_seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (resp_valid) rv_seen++;
    end
    chk("rst_probe_no_resp", 32'(rv_seen), 32'd0);
    chk("rst_probe_ready", 32'(req_ready), 32'd1);
    chk("rst_probe_pvpn2", 32'(p_ivpn2), 32'd0);
    do_req(32'hA000_0040, 8'd0, 1'b0, 0, -1, 0, "post_rst_kseg");
    do_req(32'h0080_2ABC, 8'd5, 1'b0, 5, -1, 0, "post_rst_miss");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
